// File: rtl/register_file_scoreboard.sv
// Parametrised multi-port register file with a per-register pending scoreboard.
// Read ports are combinational. Writes, pending bits and the pending count
// update on the rising clock edge. Reset is asynchronous and active-low.
module register_file_scoreboard #(
    parameter int unsigned BIT_COUNT      = 32,
    parameter int unsigned REGISTER_COUNT = 32,
    parameter int unsigned READ_PORTS     = 2,
    parameter int unsigned WRITE_PORTS    = 1,
    parameter int unsigned BYPASS         = 1,
    parameter int unsigned ZERO_REG       = 1,
    localparam int unsigned AW = (REGISTER_COUNT > 1) ? $clog2(REGISTER_COUNT) : 1,
    localparam int unsigned CW = $clog2(REGISTER_COUNT + 1)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [WRITE_PORTS-1:0]                 WriteEnable,
    input  logic [WRITE_PORTS-1:0][AW-1:0]         rdAdr,
    input  logic [WRITE_PORTS-1:0][BIT_COUNT-1:0]  Rd,
    input  logic [READ_PORTS-1:0][AW-1:0]          rsAdr,
    output logic [READ_PORTS-1:0][BIT_COUNT-1:0]   Rs,
    output logic [READ_PORTS-1:0]                  RsReady,
    input  logic                                   IssueEnable,
    input  logic [AW-1:0]                          IssueAdr,
    input  logic                                   Flush,
    output logic [CW-1:0]                          PendingCount,
    output logic                                   AnyPending
);

    logic [BIT_COUNT-1:0]      regs_q [REGISTER_COUNT];
    logic [BIT_COUNT-1:0]      regs_d [REGISTER_COUNT];
    logic [REGISTER_COUNT-1:0] pend_q;
    logic [REGISTER_COUNT-1:0] pend_d;
    logic [REGISTER_COUNT-1:0] wr_hit;
    logic [CW-1:0]             cnt_q;
    logic [CW-1:0]             cnt_d;
    logic                      any_q;
    logic [READ_PORTS-1:0]     byp;

    // Index lies inside the implemented register range (matters only for non-power-of-two counts).
    function automatic logic in_range(input logic [AW-1:0] a);
        return (32'(a) < REGISTER_COUNT);
    endfunction

    // Index is the hardwired-zero register.
    function automatic logic is_zero_reg(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Write decode: ascending port scan so the highest-index port wins a conflict.
    always_comb begin
        regs_d = regs_q;
        wr_hit = '0;
        for (int unsigned i = 0; i < REGISTER_COUNT; i++) begin
            for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
                if (WriteEnable[p] && (rdAdr[p] == AW'(i)) && !is_zero_reg(AW'(i))) begin
                    wr_hit[i] = 1'b1;
                    regs_d[i] = Rd[p];
                end
            end
        end
    end

    // Scoreboard next state: flush, then issue, then writeback clear, then hold.
    always_comb begin
        pend_d = pend_q;
        cnt_d  = '0;
        for (int unsigned i = 0; i < REGISTER_COUNT; i++) begin
            if (Flush) begin
                pend_d[i] = 1'b0;
            end else if (IssueEnable && (IssueAdr == AW'(i)) && !is_zero_reg(AW'(i))) begin
                pend_d[i] = 1'b1;
            end else if (wr_hit[i]) begin
                pend_d[i] = 1'b0;
            end
            cnt_d = cnt_d + CW'(pend_d[i]);
        end
    end

    // Read ports with optional same-cycle forwarding; bypass is held off while in reset.
    always_comb begin
        Rs      = '0;
        RsReady = '1;
        byp     = '0;
        for (int unsigned r = 0; r < READ_PORTS; r++) begin
            if (in_range(rsAdr[r]) && !is_zero_reg(rsAdr[r])) begin
                Rs[r] = regs_q[rsAdr[r]];
                if ((BYPASS != 0) && reset) begin
                    for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
                        if (WriteEnable[p] && (rdAdr[p] == rsAdr[r])) begin
                            Rs[r]  = Rd[p];
                            byp[r] = 1'b1;
                        end
                    end
                end
                RsReady[r] = !pend_q[rsAdr[r]] || byp[r];
            end
        end
    end

    // State registers: storage, pending bits and the derived count/flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < REGISTER_COUNT; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
            cnt_q  <= '0;
            any_q  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < REGISTER_COUNT; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            any_q  <= (cnt_d != '0);
        end
    end

    assign PendingCount = cnt_q;
    assign AnyPending   = any_q;

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Self-checking bench for register_file_scoreboard (2 read, 2 write ports).
module tb_register_file_scoreboard;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       WriteEnable;
    logic [1:0][4:0]  rdAdr;
    logic [1:0][31:0] Rd;
    logic [1:0][4:0]  rsAdr;
    logic [1:0][31:0] Rs;
    logic [1:0]       RsReady;
    logic             IssueEnable;
    logic [4:0]       IssueAdr;
    logic             Flush;
    logic [5:0]       PendingCount;
    logic             AnyPending;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_reg  [32];
    bit          m_pend [32];

    register_file_scoreboard #(
        .BIT_COUNT      (32),
        .REGISTER_COUNT (32),
        .READ_PORTS     (2),
        .WRITE_PORTS    (2),
        .BYPASS         (1),
        .ZERO_REG       (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .WriteEnable  (WriteEnable),
        .rdAdr        (rdAdr),
        .Rd           (Rd),
        .rsAdr        (rsAdr),
        .Rs           (Rs),
        .RsReady      (RsReady),
        .IssueEnable  (IssueEnable),
        .IssueAdr     (IssueAdr),
        .Flush        (Flush),
        .PendingCount (PendingCount),
        .AnyPending   (AnyPending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        WriteEnable = '0;
        rdAdr       = '0;
        Rd          = '0;
        IssueEnable = 1'b0;
        IssueAdr    = '0;
        Flush       = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    // Architectural read: x0 is zero, otherwise the latest write this cycle, else storage.
    function automatic logic [31:0] exp_rs(input logic [4:0] a);
        logic [31:0] v;
        if (a == 0) return 32'h0;
        v = m_reg[a];
        for (int p = 0; p < 2; p++)
            if (WriteEnable[p] && rdAdr[p] == a) v = Rd[p];
        return v;
    endfunction

    function automatic logic exp_rdy(input logic [4:0] a);
        if (a == 0) return 1'b1;
        for (int p = 0; p < 2; p++)
            if (WriteEnable[p] && rdAdr[p] == a) return 1'b1;
        return !m_pend[a];
    endfunction

    task automatic check_reads(input string tag);
        for (int r = 0; r < 2; r++) begin
            check($sformatf("%s_rs%0d", tag, r), 64'(Rs[r]), 64'(exp_rs(rsAdr[r])));
            check($sformatf("%s_rdy%0d", tag, r), 64'(RsReady[r]), 64'(exp_rdy(rsAdr[r])));
        end
    endtask

    task automatic check_count(input string tag);
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
        check({tag, "_cnt"}, 64'(PendingCount), 64'(c));
        check({tag, "_any"}, 64'(AnyPending), 64'(c != 0));
    endtask

    // Apply this cycle's inputs to the model, then advance one clock edge.
    task automatic tick();
        for (int p = 0; p < 2; p++) begin
            if (WriteEnable[p] && rdAdr[p] != 0) begin
                m_reg[rdAdr[p]]  = Rd[p];
                m_pend[rdAdr[p]] = 1'b0;
            end
        end
        if (IssueEnable && IssueAdr != 0) m_pend[IssueAdr] = 1'b1;
        if (Flush) for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        rsAdr = '0;
        model_reset();

        // Reset state
        @(posedge clk); #1;
        rsAdr[0] = 5'd5; rsAdr[1] = 5'd0;
        #1;
        check_reads("rst");
        check_count("rst");
        @(posedge clk); #1;
        reset = 1'b1;

        // Write x5 with same-cycle bypass, then read from storage
        WriteEnable[0] = 1'b1; rdAdr[0] = 5'd5; Rd[0] = 32'hDEADBEEF;
        #1;
        check("byp_x5", 64'(Rs[0]), 64'h0DEADBEEF);
        check("byp_x5_rdy", 64'(RsReady[0]), 64'h1);
        tick();
        idle();
        #1;
        check("st_x5", 64'(Rs[0]), 64'h0DEADBEEF);
        check_reads("st_x5");

        // Hardwired zero: write and issue x0 both ignored
        WriteEnable[0] = 1'b1; rdAdr[0] = 5'd0; Rd[0] = 32'h1234;
        IssueEnable = 1'b1; IssueAdr = 5'd0; rsAdr[0] = 5'd0;
        #1;
        check("x0_byp", 64'(Rs[0]), 64'h0);
        tick();
        idle();
        #1;
        check("x0_rs", 64'(Rs[0]), 64'h0);
        check("x0_rdy", 64'(RsReady[0]), 64'h1);
        check("x0_cnt", 64'(PendingCount), 64'h0);

        // Two ports write x7: highest port wins
        WriteEnable = 2'b11; rdAdr[0] = 5'd7; rdAdr[1] = 5'd7;
        Rd[0] = 32'h11; Rd[1] = 32'h22; rsAdr[1] = 5'd7;
        #1;
        check("x7_byp", 64'(Rs[1]), 64'h22);
        tick();
        idle();
        #1;
        check("x7_st", 64'(Rs[1]), 64'h22);

        // Issue x3, then writeback with bypass
        IssueEnable = 1'b1; IssueAdr = 5'd3; rsAdr[0] = 5'd3;
        tick();
        idle();
        #1;
        check("x3_rdy0", 64'(RsReady[0]), 64'h0);
        check("x3_cnt1", 64'(PendingCount), 64'h1);
        WriteEnable[0] = 1'b1; rdAdr[0] = 5'd3; Rd[0] = 32'h55;
        #1;
        check("x3_wb_rdy", 64'(RsReady[0]), 64'h1);
        check("x3_wb_rs", 64'(Rs[0]), 64'h55);
        tick();
        idle();
        #1;
        check("x3_cnt0", 64'(PendingCount), 64'h0);
        check("x3_any0", 64'(AnyPending), 64'h0);

        // Issue beats same-cycle writeback
        IssueEnable = 1'b1; IssueAdr = 5'd4;
        WriteEnable[0] = 1'b1; rdAdr[0] = 5'd4; Rd[0] = 32'h44;
        tick();
        idle();
        rsAdr[0] = 5'd4;
        #1;
        check("x4_cnt", 64'(PendingCount), 64'h1);
        check("x4_rdy", 64'(RsReady[0]), 64'h0);
        for (int k = 1; k <= 3; k++) begin
            IssueEnable = 1'b1; IssueAdr = 5'(k);
            tick();
        end
        idle();
        check("pre_flush_cnt", 64'(PendingCount), 64'h4);
        check_count("pre_flush");
        Flush = 1'b1; IssueEnable = 1'b1; IssueAdr = 5'd9;
        tick();
        idle();
        check("flush_cnt", 64'(PendingCount), 64'h0);
        check("flush_any", 64'(AnyPending), 64'h0);

        // Asynchronous reset mid-cycle
        WriteEnable[0] = 1'b1; rdAdr[0] = 5'd8; Rd[0] = 32'hAA;
        tick();
        idle();
        IssueEnable = 1'b1; IssueAdr = 5'd8;
        tick();
        idle();
        rsAdr[0] = 5'd8;
        #1;
        check("x8_pre_rs", 64'(Rs[0]), 64'hAA);
        check("x8_pre_cnt", 64'(PendingCount), 64'h1);
        WriteEnable[0] = 1'b1; rdAdr[0] = 5'd8; Rd[0] = 32'hBB;
        #1;
        reset = 1'b0;
        #1;
        check("arst_rs", 64'(Rs[0]), 64'h0);
        check("arst_rdy", 64'(RsReady[0]), 64'h1);
        check("arst_cnt", 64'(PendingCount), 64'h0);
        check("arst_any", 64'(AnyPending), 64'h0);
        idle();
        model_reset();
        @(posedge clk); #1;
        reset = 1'b1;

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) begin
                WriteEnable[p] = ($urandom_range(0, 2) == 0);
                rdAdr[p]       = 5'($urandom_range(0, 11));
                Rd[p]          = $urandom;
            end
            for (int r = 0; r < 2; r++) rsAdr[r] = 5'($urandom_range(0, 11));
            IssueEnable = ($urandom_range(0, 1) == 1);
            IssueAdr    = 5'($urandom_range(0, 11));
            Flush       = ($urandom_range(0, 24) == 0);
            #1;
            check_reads("rnd");
            tick();
            check_count("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
